hilo_pipe: RTL and testbench



---
 rtl/hilo_pipe.sv | 80 ++++++++
 tb/tb_hilo_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_pipe.sv
// HI/LO write path: carries execute-stage requests through the EX/MEM and MEM/WB
// slots and commits them into the architectural HI/LO registers.
module hilo_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             flush,
  input  logic             ex_hilo_i,
  input  logic [WIDTH-1:0] ex_hi_i,
  input  logic [WIDTH-1:0] ex_lo_i,
  output logic             mem_hilo_o,
  output logic [WIDTH-1:0] mem_hi_o,
  output logic [WIDTH-1:0] mem_lo_o,
  output logic             wb_hilo_o,
  output logic [WIDTH-1:0] wb_hi_o,
  output logic [WIDTH-1:0] wb_lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  // EX/MEM slot: a bubble goes in only at the stalled/unstalled boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_hilo_o <= 1'b0;
      mem_hi_o   <= '0;
      mem_lo_o   <= '0;
    end else if (flush) begin
      mem_hilo_o <= 1'b0;
      mem_hi_o   <= '0;
      mem_lo_o   <= '0;
    end else if (stall[STALL_EX] && !stall[STALL_MEM]) begin
      mem_hilo_o <= 1'b0;
      mem_hi_o   <= '0;
      mem_lo_o   <= '0;
    end else if (!stall[STALL_EX]) begin
      mem_hilo_o <= ex_hilo_i;
      mem_hi_o   <= ex_hi_i;
      mem_lo_o   <= ex_lo_i;
    end
  end

  // MEM/WB slot, same rules shifted one stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_hilo_o <= 1'b0;
      wb_hi_o   <= '0;
      wb_lo_o   <= '0;
    end else if (flush) begin
      wb_hilo_o <= 1'b0;
      wb_hi_o   <= '0;
      wb_lo_o   <= '0;
    end else if (stall[STALL_MEM] && !stall[STALL_WB]) begin
      wb_hilo_o <= 1'b0;
      wb_hi_o   <= '0;
      wb_lo_o   <= '0;
    end else if (!stall[STALL_MEM]) begin
      wb_hilo_o <= mem_hilo_o;
      wb_hi_o   <= mem_hi_o;
      wb_lo_o   <= mem_lo_o;
    end
  end

  // Commit ignores flush: the WB instruction has already retired
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (wb_hilo_o && !stall[STALL_WB]) begin
      hi_o <= wb_hi_o;
      lo_o <= wb_lo_o;
    end
  end

endmodule

// File: tb/tb_hilo_pipe.sv
// Directed bench for hilo_pipe: stimulus pushes expected commits into a queue,
// a negedge monitor pops and checks HI/LO whenever a commit takes place.
module tb_hilo_pipe;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         ex_hilo_i;
  logic [W-1:0] ex_hi_i;
  logic [W-1:0] ex_lo_i;
  logic         mem_hilo_o;
  logic [W-1:0] mem_hi_o;
  logic [W-1:0] mem_lo_o;
  logic         wb_hilo_o;
  logic [W-1:0] wb_hi_o;
  logic [W-1:0] wb_lo_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  bit             pend = 0;
  logic [2*W-1:0] pend_val;

  hilo_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_hilo_i(ex_hilo_i), .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i),
    .mem_hilo_o(mem_hilo_o), .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o),
    .wb_hilo_o(wb_hilo_o), .wb_hi_o(wb_hi_o), .wb_lo_o(wb_lo_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic h, input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input logic [5:0] st, input logic fl);
    ex_hilo_i = h;
    ex_hi_i   = hi;
    ex_lo_i   = lo;
    stall     = st;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 6'b0, 1'b0);
  endtask

  // Monitor: a commit seen pending at one negedge is checked at the next
  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if ({hi_o, lo_o} !== pend_val) begin
        errors++;
        $display("FAIL commit: got hi/lo %h/%h expected %h/%h at %0t",
                 hi_o, lo_o, pend_val[2*W-1:W], pend_val[W-1:0], $time);
      end
      pend = 0;
    end
    if (!rst && wb_hilo_o && !stall[5]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: wb hi/lo %h/%h with no expected commit at %0t",
                 wb_hi_o, wb_lo_o, $time);
      end else begin
        pend_val = exp_q.pop_front();
        pend = 1;
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    #12;
    chk("reset_mem_hilo", W'(mem_hilo_o), '0);
    chk("reset_wb_hilo", W'(wb_hilo_o), '0);
    chk("reset_hi", hi_o, '0);
    chk("reset_lo", lo_o, '0);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick();
    chk("post_reset_mem_hilo", W'(mem_hilo_o), '0);
    chk("post_reset_hi", hi_o, '0);

    // Single request
    drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 6'b0, 1'b0);
    exp_q.push_back({32'h12345678, 32'h9ABCDEF0});
    tick();
    chk("single_mem_hilo", W'(mem_hilo_o), 1);
    chk("single_mem_hi", mem_hi_o, 32'h12345678);
    chk("single_mem_lo", mem_lo_o, 32'h9ABCDEF0);
    chk("single_wb_hilo0", W'(wb_hilo_o), 0);
    idle();
    tick();
    chk("single_mem_hilo_drop", W'(mem_hilo_o), 0);
    chk("single_wb_hilo", W'(wb_hilo_o), 1);
    chk("single_wb_lo", wb_lo_o, 32'h9ABCDEF0);
    chk("single_hi_before", hi_o, 0);
    tick();
    chk("single_wb_hilo_drop", W'(wb_hilo_o), 0);
    chk("single_hi", hi_o, 32'h12345678);
    chk("single_lo", lo_o, 32'h9ABCDEF0);
    tick();
    chk("single_hi_persist", hi_o, 32'h12345678);

    // Back-to-back
    drive(1'b1, 32'd1, 32'd2, 6'b0, 1'b0);
    exp_q.push_back({32'd1, 32'd2});
    tick();
    chk("b2b_mem_hi_a", mem_hi_o, 1);
    drive(1'b1, 32'd3, 32'd4, 6'b0, 1'b0);
    exp_q.push_back({32'd3, 32'd4});
    tick();
    chk("b2b_mem_hilo_b", W'(mem_hilo_o), 1);
    chk("b2b_mem_hi_b", mem_hi_o, 3);
    chk("b2b_wb_hilo_a", W'(wb_hilo_o), 1);
    chk("b2b_wb_hi_a", wb_hi_o, 1);
    idle();
    tick();
    chk("b2b_wb_hilo_b", W'(wb_hilo_o), 1);
    chk("b2b_wb_lo_b", wb_lo_o, 4);
    chk("b2b_hi_a", hi_o, 1);
    chk("b2b_lo_a", lo_o, 2);
    tick();
    chk("b2b_hi_b", hi_o, 3);
    chk("b2b_lo_b", lo_o, 4);

    // EX stall: request waits, enters MEM exactly once
    drive(1'b1, 32'hAAAA, 32'hBBBB, 6'b001111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("exstall_mem_hilo", W'(mem_hilo_o), 0);
    end
    drive(1'b1, 32'hAAAA, 32'hBBBB, 6'b0, 1'b0);
    exp_q.push_back({32'hAAAA, 32'hBBBB});
    tick();
    chk("exstall_mem_hilo_go", W'(mem_hilo_o), 1);
    chk("exstall_mem_hi", mem_hi_o, 32'hAAAA);
    idle();
    tick();
    chk("exstall_mem_hilo_once", W'(mem_hilo_o), 0);
    chk("exstall_wb_hilo", W'(wb_hilo_o), 1);
    tick();
    chk("exstall_wb_hilo_once", W'(wb_hilo_o), 0);
    chk("exstall_hi", hi_o, 32'hAAAA);
    chk("exstall_lo", lo_o, 32'hBBBB);

    // MEM stall: MEM slot holds, WB gets a bubble
    drive(1'b1, 32'hC1, 32'hC2, 6'b0, 1'b0);
    exp_q.push_back({32'hC1, 32'hC2});
    tick();
    chk("memstall_mem_hilo", W'(mem_hilo_o), 1);
    drive(1'b0, '0, '0, 6'b011111, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("memstall_hold_hilo", W'(mem_hilo_o), 1);
      chk("memstall_hold_hi", mem_hi_o, 32'hC1);
      chk("memstall_wb_bubble", W'(wb_hilo_o), 0);
    end
    idle();
    tick();
    chk("memstall_mem_drained", W'(mem_hilo_o), 0);
    chk("memstall_wb_hilo", W'(wb_hilo_o), 1);
    chk("memstall_wb_hi", wb_hi_o, 32'hC1);
    tick();
    chk("memstall_hi", hi_o, 32'hC1);
    chk("memstall_lo", lo_o, 32'hC2);

    // Flush: WB request still commits, both slots cleared
    drive(1'b1, 32'hD1, 32'hD2, 6'b0, 1'b0);
    exp_q.push_back({32'hD1, 32'hD2});
    tick();
    drive(1'b1, 32'hE1, 32'hE2, 6'b0, 1'b0);
    tick();
    chk("flush_pre_wb_hilo", W'(wb_hilo_o), 1);
    chk("flush_pre_mem_hi", mem_hi_o, 32'hE1);
    drive(1'b0, '0, '0, 6'b0, 1'b1);
    tick();
    chk("flush_mem_hilo", W'(mem_hilo_o), 0);
    chk("flush_mem_hi", mem_hi_o, 0);
    chk("flush_wb_hilo", W'(wb_hilo_o), 0);
    chk("flush_hi", hi_o, 32'hD1);
    chk("flush_lo", lo_o, 32'hD2);
    idle();
    tick(); tick();
    chk("flush_hi_persist", hi_o, 32'hD1);

    // Reset mid-operation discards in-flight requests asynchronously
    drive(1'b1, 32'hF1, 32'hF2, 6'b0, 1'b0);
    tick();
    drive(1'b1, 32'hF3, 32'hF4, 6'b0, 1'b0);
    tick();
    chk("midrst_pre_wb_hi", wb_hi_o, 32'hF1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_mem_hilo", W'(mem_hilo_o), 0);
    chk("midrst_mem_hi", mem_hi_o, 0);
    chk("midrst_wb_hilo", W'(wb_hilo_o), 0);
    chk("midrst_hi", hi_o, 0);
    chk("midrst_lo", lo_o, 0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("midrst_after_hi", hi_o, 0);
    chk("midrst_after_wb_hilo", W'(wb_hilo_o), 0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", W'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
